instruction_fetch_unit: RTL

//  Initiator side of the instruction-memory read interface. Holds the PC and drives the
//  64-bit byte address into the combinational read-only instruction memory. Waits a fixed

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_wait_counter.sv | 36 +++
 rtl/instruction_fetch_unit.sv | 120 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    localparam int unsigned INST_BYTES = 4;
    localparam int unsigned ADDR_W     = 64;
    localparam int unsigned INST_W     = 32;

    typedef enum logic [0:0] {
        FETCH,
        HOLD
    } fetch_state_e;

    // Clear the byte-offset bits so the address points at a whole instruction.
    function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] pc);
        return pc & ~ADDR_W'(INST_BYTES - 1);
    endfunction

endpackage

// File: rtl/fetch_wait_counter.sv
// Counts the cycles the fetch address has been held; done flags the sampling cycle.
module fetch_wait_counter #(
    parameter int unsigned RD_WAIT = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic done_o
);

    localparam int unsigned CntW = $clog2(RD_WAIT + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(RD_WAIT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign done_o = (cnt_q == LastCnt);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = done_o ? '0 : cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// PC holder and instruction-memory read initiator with valid/ready output to decode.
// Optional misaligned-fetch detection is enabled by defining FETCH_ALIGN_CHECK_EN.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned       RD_WAIT  = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = 64'h0
) (
    input  logic              CLK,
    input  logic              Reset_L,
    input  logic              Redirect,
    input  logic [ADDR_W-1:0] RedirectPC,
    output logic [ADDR_W-1:0] IMemAddr,
    input  logic [INST_W-1:0] IMemData,
    output logic              InstValid,
    input  logic              InstReady,
    output logic [INST_W-1:0] Inst,
    output logic [ADDR_W-1:0] InstPC,
    output logic              AlignFault
);

`ifdef FETCH_ALIGN_CHECK_EN
    localparam logic [ADDR_W-1:0] ResetPc = RESET_PC;
`else
    localparam logic [ADDR_W-1:0] ResetPc = align_pc(RESET_PC);
`endif

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
    logic              valid_q, valid_d;
    logic              fault_q, fault_d;
    logic              misaligned;
    logic              fetch_en;
    logic              cnt_done;

`ifdef FETCH_ALIGN_CHECK_EN
    assign misaligned = |pc_q[1:0];
`else
    assign misaligned = 1'b0;
`endif

    // A misaligned PC parks the unit in FETCH without counting toward a capture.
    assign fetch_en = (state_q == FETCH) && !misaligned;

    fetch_wait_counter #(
        .RD_WAIT (RD_WAIT)
    ) u_wait_counter (
        .clk_i    (CLK),
        .rst_ni   (Reset_L),
        .clear_i  (Redirect),
        .enable_i (fetch_en),
        .done_o   (cnt_done)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        valid_d   = valid_q;
        fault_d   = fault_q;
        if (Redirect) begin
            state_d = FETCH;
            valid_d = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            pc_d    = RedirectPC;
            fault_d = |RedirectPC[1:0];
`else
            pc_d    = align_pc(RedirectPC);
`endif
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (misaligned) begin
                        fault_d = 1'b1;
                    end else if (cnt_done) begin
                        inst_d    = IMemData;
                        inst_pc_d = pc_q;
                        valid_d   = 1'b1;
                        pc_d      = pc_q + ADDR_W'(INST_BYTES);
                        state_d   = HOLD;
                    end
                end
                HOLD: begin
                    if (InstReady) begin
                        valid_d = 1'b0;
                        state_d = FETCH;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state_q   <= FETCH;
            pc_q      <= ResetPc;
            inst_q    <= '0;
            inst_pc_q <= '0;
            valid_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            valid_q   <= valid_d;
            fault_q   <= fault_d;
        end
    end

    assign IMemAddr   = pc_q;
    assign InstValid  = valid_q;
    assign Inst       = inst_q;
    assign InstPC     = inst_pc_q;
    assign AlignFault = fault_q;

endmodule
